// File: rtl/noc_pkg.sv
// Shared NoC router types: flit width, merge FSM states and the flit record.
package noc_pkg;

  localparam int FLIT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } merge_state_t;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic              tail;
  } flit_t;

endpackage

// File: rtl/packet_merge_arb_if.sv
// Flit stream channel: payload, last-flit marker and valid/ready handshake.
import noc_pkg::*;

interface packet_merge_arb_if #(
  parameter int WIDTH = FLIT_W
);
  logic [WIDTH-1:0] data;
  logic             tail;
  logic             valid;
  logic             ready;

  modport master (output data, output tail, output valid, input ready);
  modport slave  (input data, input tail, input valid, output ready);
endinterface

// File: rtl/noc_out_reg.sv
// Single-entry valid/ready pipeline register. The caller only presents
// in_valid in cycles where load is high, so a captured flit is never lost.
import noc_pkg::*;

module noc_out_reg #(
  parameter int WIDTH = FLIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_tail,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_tail,
  output logic             load
);

  // Register may accept a new flit when empty or when draining this cycle.
  assign load = !out_valid || out_ready;

  // Capture the incoming flit, or clear valid when the held flit drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_tail <= in_tail;
      end
    end
  end

endmodule

// File: rtl/packet_merge_arb.sv
// Two-input packet merge: round-robin per packet, granted input holds the
// channel until its tail flit transfers, single registered output stage.
import noc_pkg::*;

module packet_merge_arb #(
  parameter int WIDTH = FLIT_W
) (
  input  logic                CLK,
  input  logic                _RESET,
  packet_merge_arb_if.slave   in0,
  packet_merge_arb_if.slave   in1,
  packet_merge_arb_if.master  out
);

  merge_state_t     state_reg, state_next;
  logic             rr_reg, rr_next;    // input that last completed a packet
  logic             grant0, grant1;
  logic             load;
  logic             xfer0, xfer1;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_tail;

  // Grant selection: locked input owns the channel, otherwise round-robin.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (in0.valid && (!in1.valid || rr_reg)) grant0 = 1'b1;
        else if (in1.valid)                      grant1 = 1'b1;
      end
      LOCK0:   grant0 = 1'b1;
      LOCK1:   grant1 = 1'b1;
      default: ;
    endcase
  end

  // Readies depend only on control state, never on payload.
  assign in0.ready = _RESET && grant0 && load;
  assign in1.ready = _RESET && grant1 && load;
  assign xfer0     = in0.valid && in0.ready;
  assign xfer1     = in1.valid && in1.ready;
  assign sel_valid = xfer0 || xfer1;
  assign sel_data  = xfer1 ? in1.data : in0.data;
  assign sel_tail  = xfer1 ? in1.tail : in0.tail;

  // Next-state and priority pointer update, driven by accepted flits.
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    unique case (state_reg)
      IDLE: begin
        if (xfer0) begin
          if (in0.tail) rr_next    = 1'b0;
          else          state_next = LOCK0;
        end else if (xfer1) begin
          if (in1.tail) rr_next    = 1'b1;
          else          state_next = LOCK1;
        end
      end
      LOCK0: begin
        if (xfer0 && in0.tail) begin
          state_next = IDLE;
          rr_next    = 1'b0;
        end
      end
      LOCK1: begin
        if (xfer1 && in1.tail) begin
          state_next = IDLE;
          rr_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset releases any lock and favours In0 first.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
    end
  end

  noc_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (CLK),
    .rst_n     (_RESET),
    .in_valid  (sel_valid),
    .in_data   (sel_data),
    .in_tail   (sel_tail),
    .out_ready (out.ready),
    .out_valid (out.valid),
    .out_data  (out.data),
    .out_tail  (out.tail),
    .load      (load)
  );

endmodule

// File: tb/tb_packet_merge_arb.sv
// Directed and random checks of the two-input packet merge arbiter.
module tb_packet_merge_arb;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  packet_merge_arb_if #(.WIDTH(FLIT_W)) in0_if ();
  packet_merge_arb_if #(.WIDTH(FLIT_W)) in1_if ();
  packet_merge_arb_if #(.WIDTH(FLIT_W)) out_if ();

  packet_merge_arb #(.WIDTH(FLIT_W)) dut (
    .CLK    (clk),
    ._RESET (rst_n),
    .in0    (in0_if),
    .in1    (in1_if),
    .out    (out_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in0_if.valid = 1'b0; in0_if.data = '0; in0_if.tail = 1'b0;
    in1_if.valid = 1'b0; in1_if.data = '0; in1_if.tail = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [8:0] d [3];
    logic       t [3];
    d = '{9'h011, 9'h022, 9'h133};
    t = '{1'b0, 1'b0, 1'b1};
    idle_inputs();
    out_if.ready = 1'b1;
    rst_n = 1'b0;
    in0_if.valid = 1'b1; in0_if.data = 9'h011; in0_if.tail = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if ({in0_if.ready, out_if.valid} !== 2'b00) begin
        $display("FAIL reset_hold: ready/out_valid got %b required 00", {in0_if.ready, out_if.valid});
        miscompares++;
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_if.data = d[i]; in0_if.tail = t[i];
      #1;
      vectors++;
      if (in0_if.ready !== 1'b1) begin
        $display("FAIL single_ready: flit %0d got %b required 1", i, in0_if.ready);
        miscompares++;
      end
      tick();
      vectors++;
      if ({out_if.valid, out_if.tail, out_if.data} !== {1'b1, t[i], d[i]}) begin
        $display("FAIL single_out: got v%b t%b %h required v1 t%b %h",
                 out_if.valid, out_if.tail, out_if.data, t[i], d[i]);
        miscompares++;
      end
    end
    in0_if.valid = 1'b0;
    tick();
    vectors++;
    if (out_if.valid !== 1'b0) begin
      $display("FAIL single_drain: out_valid got %b required 0", out_if.valid);
      miscompares++;
    end
  endtask

  task automatic test_contention;
    logic [8:0] e0, e1;
    idle_inputs();
    out_if.ready = 1'b1;
    do_reset(2);
    for (int r = 0; r < 2; r++) begin
      e0 = 9'h0AA + 9'(r);
      e1 = 9'h155 + 9'(r);
      in0_if.valid = 1'b1; in0_if.data = e0; in0_if.tail = 1'b1;
      in1_if.valid = 1'b1; in1_if.data = e1; in1_if.tail = 1'b1;
      #1;
      vectors++;
      if ({in0_if.ready, in1_if.ready} !== 2'b10) begin
        $display("FAIL cont_grant_in0: readies got %b required 10", {in0_if.ready, in1_if.ready});
        miscompares++;
      end
      tick();
      vectors++;
      if ({out_if.valid, out_if.tail, out_if.data} !== {2'b11, e0}) begin
        $display("FAIL cont_out0: got %h required %h", out_if.data, e0);
        miscompares++;
      end
      in0_if.valid = 1'b0;
      #1;
      vectors++;
      if ({in0_if.ready, in1_if.ready} !== 2'b01) begin
        $display("FAIL cont_then_in1: readies got %b required 01", {in0_if.ready, in1_if.ready});
        miscompares++;
      end
      tick();
      vectors++;
      if ({out_if.valid, out_if.tail, out_if.data} !== {2'b11, e1}) begin
        $display("FAIL cont_out1: got %h required %h", out_if.data, e1);
        miscompares++;
      end
      in1_if.valid = 1'b0;
    end
    // In0 alone completes a packet, so In1 must win the next contention.
    in0_if.valid = 1'b1; in0_if.data = 9'h0A0; in0_if.tail = 1'b1;
    tick();
    in0_if.data = 9'h0A1;
    in1_if.valid = 1'b1; in1_if.data = 9'h151; in1_if.tail = 1'b1;
    #1;
    vectors++;
    if ({in0_if.ready, in1_if.ready} !== 2'b01) begin
      $display("FAIL cont_grant_in1: readies got %b required 01", {in0_if.ready, in1_if.ready});
      miscompares++;
    end
    tick();
    vectors++;
    if (out_if.data !== 9'h151) begin
      $display("FAIL cont_out_in1: got %h required 151", out_if.data);
      miscompares++;
    end
    in1_if.valid = 1'b0;
    tick();
    vectors++;
    if (out_if.data !== 9'h0A1) begin
      $display("FAIL cont_out_in0_late: got %h required 0a1", out_if.data);
      miscompares++;
    end
    in0_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_packet_lock;
    logic [8:0] d [3];
    d = '{9'h001, 9'h002, 9'h103};
    in1_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1_if.data = d[i]; in1_if.tail = (i == 2);
      if (i == 1) begin
        in0_if.valid = 1'b1; in0_if.data = 9'h0CC; in0_if.tail = 1'b1;
      end
      #1;
      vectors++;
      if ({in0_if.ready, in1_if.ready} !== 2'b01) begin
        $display("FAIL lock_ready: flit %0d readies got %b required 01", i, {in0_if.ready, in1_if.ready});
        miscompares++;
      end
      tick();
      vectors++;
      if ({out_if.valid, out_if.tail, out_if.data} !== {1'b1, (i == 2), d[i]}) begin
        $display("FAIL lock_out: got t%b %h required t%b %h", out_if.tail, out_if.data, (i == 2), d[i]);
        miscompares++;
      end
    end
    in1_if.valid = 1'b0;
    #1;
    vectors++;
    if (in0_if.ready !== 1'b1) begin
      $display("FAIL lock_release: in0_ready got %b required 1", in0_if.ready);
      miscompares++;
    end
    tick();
    vectors++;
    if ({out_if.valid, out_if.data} !== {1'b1, 9'h0CC}) begin
      $display("FAIL lock_follow: got v%b %h required v1 0cc", out_if.valid, out_if.data);
      miscompares++;
    end
    in0_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    logic [8:0] e;
    in0_if.valid = 1'b1; in0_if.data = 9'h040; in0_if.tail = 1'b0;
    tick();
    out_if.ready = 1'b0;
    in0_if.data = 9'h041;
    repeat (5) begin
      #1;
      vectors++;
      if ({in0_if.ready, out_if.valid, out_if.tail, out_if.data} !== {3'b010, 9'h040}) begin
        $display("FAIL bp_hold: ready %b out v%b %h required ready 0 out v1 040",
                 in0_if.ready, out_if.valid, out_if.data);
        miscompares++;
      end
      tick();
    end
    out_if.ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      e = 9'h040 + 9'(i);
      in0_if.data = e; in0_if.tail = (i == 3);
      #1;
      vectors++;
      if (in0_if.ready !== 1'b1) begin
        $display("FAIL bp_resume_ready: flit %0d got %b required 1", i, in0_if.ready);
        miscompares++;
      end
      tick();
      vectors++;
      if ({out_if.valid, out_if.tail, out_if.data} !== {1'b1, (i == 3), e}) begin
        $display("FAIL bp_resume_out: got %h required %h", out_if.data, e);
        miscompares++;
      end
    end
    in0_if.valid = 1'b0;
    tick();
    vectors++;
    if (out_if.valid !== 1'b0) begin
      $display("FAIL bp_drain: out_valid got %b required 0", out_if.valid);
      miscompares++;
    end
  endtask

  task automatic test_source_gap;
    in0_if.valid = 1'b1; in0_if.data = 9'h050; in0_if.tail = 1'b0;
    tick();
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b1; in1_if.data = 9'h1EE; in1_if.tail = 1'b1;
    repeat (3) begin
      #1;
      vectors++;
      if (in1_if.ready !== 1'b0) begin
        $display("FAIL gap_lock: in1_ready got %b required 0", in1_if.ready);
        miscompares++;
      end
      tick();
      vectors++;
      if (out_if.valid !== 1'b0) begin
        $display("FAIL gap_out: out_valid got %b required 0", out_if.valid);
        miscompares++;
      end
    end
    in0_if.valid = 1'b1; in0_if.data = 9'h051; in0_if.tail = 1'b1;
    #1;
    vectors++;
    if ({in0_if.ready, in1_if.ready} !== 2'b10) begin
      $display("FAIL gap_tail_ready: readies got %b required 10", {in0_if.ready, in1_if.ready});
      miscompares++;
    end
    tick();
    vectors++;
    if ({out_if.valid, out_if.tail, out_if.data} !== {2'b11, 9'h051}) begin
      $display("FAIL gap_tail_out: got t%b %h required t1 051", out_if.tail, out_if.data);
      miscompares++;
    end
    in0_if.valid = 1'b0;
    tick();
    vectors++;
    if (out_if.data !== 9'h1EE) begin
      $display("FAIL gap_in1_out: got %h required 1ee", out_if.data);
      miscompares++;
    end
    in1_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    in0_if.valid = 1'b1; in0_if.data = 9'h060; in0_if.tail = 1'b0;
    tick();
    in0_if.data = 9'h061;
    tick();
    rst_n = 1'b0;
    in0_if.data = 9'h062;
    #1;
    vectors++;
    if ({in0_if.ready, in1_if.ready} !== 2'b00) begin
      $display("FAIL rstmid_ready: readies got %b required 00", {in0_if.ready, in1_if.ready});
      miscompares++;
    end
    tick();
    vectors++;
    if ({out_if.valid, out_if.tail, out_if.data} !== 11'd0) begin
      $display("FAIL rstmid_drop: got v%b t%b %h required v0 t0 000",
               out_if.valid, out_if.tail, out_if.data);
      miscompares++;
    end
    rst_n = 1'b1;
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b1; in1_if.data = 9'h170; in1_if.tail = 1'b1;
    #1;
    vectors++;
    if ({in0_if.ready, in1_if.ready} !== 2'b01) begin
      $display("FAIL rstmid_grant: readies got %b required 01", {in0_if.ready, in1_if.ready});
      miscompares++;
    end
    tick();
    vectors++;
    if ({out_if.valid, out_if.tail, out_if.data} !== {2'b11, 9'h170}) begin
      $display("FAIL rstmid_fresh: got %h required 170", out_if.data);
      miscompares++;
    end
    in1_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic       gv [2];
    logic [8:0] gd [2];
    logic       gt [2];
    logic       rdy [2];
    logic [7:0] seq [2];
    int         left [2];
    int         pkts [2];
    flit_t      q0 [$];
    flit_t      q1 [$];
    flit_t      exp_f, got_f;
    int         lock_src, src, cycles, nflit;
    bit         empty;
    for (int k = 0; k < 2; k++) begin
      gv[k] = 1'b0; gd[k] = '0; gt[k] = 1'b0; seq[k] = '0; left[k] = 0; pkts[k] = 0;
    end
    lock_src = -1; cycles = 0; nflit = 0;
    idle_inputs();
    out_if.ready = 1'b0;
    do_reset(2);
    while (cycles < 50000) begin
      if (pkts[0] == 500 && pkts[1] == 500 && left[0] == 0 && left[1] == 0 &&
          !gv[0] && !gv[1] && !out_if.valid) break;
      for (int k = 0; k < 2; k++) begin
        if (!gv[k] && (left[k] > 0 || pkts[k] < 500) && $urandom_range(0, 3) != 0) begin
          if (left[k] == 0) begin
            left[k] = int'($urandom_range(1, 4));
            pkts[k]++;
          end
          gd[k] = {k[0], seq[k]};
          gt[k] = (left[k] == 1);
          gv[k] = 1'b1;
        end
      end
      in0_if.valid = gv[0]; in0_if.data = gd[0]; in0_if.tail = gt[0];
      in1_if.valid = gv[1]; in1_if.data = gd[1]; in1_if.tail = gt[1];
      out_if.ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy[0] = in0_if.ready;
      rdy[1] = in1_if.ready;
      vectors++;
      if (rdy[0] && rdy[1]) begin
        $display("FAIL rand_both_ready: readies got 11 required at most one");
        miscompares++;
      end
      if (out_if.valid && out_if.ready) begin
        got_f.data = out_if.data;
        got_f.tail = out_if.tail;
        src = int'(got_f.data[8]);
        empty = (src == 0) ? (q0.size() == 0) : (q1.size() == 0);
        vectors++;
        if (empty) begin
          $display("FAIL rand_unexpected: flit %h from input %0d required none pending", got_f.data, src);
          miscompares++;
        end else begin
          exp_f = (src == 0) ? q0.pop_front() : q1.pop_front();
          if (got_f !== exp_f) begin
            $display("FAIL rand_flit: got %h t%b required %h t%b", got_f.data, got_f.tail, exp_f.data, exp_f.tail);
            miscompares++;
          end else begin
            $display("flit %0d input %0d data %h tail %b CORRECT", nflit, src, got_f.data, got_f.tail);
          end
        end
        vectors++;
        if (lock_src != -1 && src != lock_src) begin
          $display("FAIL rand_interleave: input %0d got channel required input %0d", src, lock_src);
          miscompares++;
        end
        lock_src = got_f.tail ? -1 : src;
        nflit++;
      end
      for (int k = 0; k < 2; k++) begin
        if (gv[k] && rdy[k]) begin
          exp_f.data = gd[k];
          exp_f.tail = gt[k];
          if (k == 0) q0.push_back(exp_f);
          else        q1.push_back(exp_f);
          seq[k]++;
          left[k]--;
          gv[k] = 1'b0;
        end
      end
      tick();
      cycles++;
    end
    vectors++;
    if (cycles >= 50000) begin
      $display("FAIL rand_timeout: %0d cycles used required fewer than 50000", cycles);
      miscompares++;
    end
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      $display("FAIL rand_leftover: pending %0d/%0d required 0/0", q0.size(), q1.size());
      miscompares++;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    out_if.ready = 1'b1;
    idle_inputs();
    test_reset();
    test_contention();
    test_packet_lock();
    test_backpressure();
    test_source_gap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
